// File: rtl/q_max_scanner.sv
`default_nettype none
// ============================================================================
// Module   : q_max_scanner
// Purpose  : Read side of the Q-table. Scans every action entry of one state
//            in the Q RAM and returns the maximum Q value together with the
//            chosen action. It sits between the Q RAM read port and the agent
//            controller / Q updater.
//
// Ports    : clk          rising-edge clock
//            rst          asynchronous reset, active high
//            start        scan request for state_in (sampled in IDLE only)
//            state_in     state to scan (latched when start is accepted)
//            busy         high from the accepted start until the DONE cycle ends
//            q_rd_en      RAM read strobe
//            q_rd_addr    RAM read address {state, action}
//            q_rd_data    RAM read data, valid exactly 1 cycle after q_rd_en
//            done         1-cycle pulse, max_q / best_action valid
//            max_q        maximum signed Q of the scanned state
//            best_action  argmax action (or an exploration action, see below)
//
// Config   : `define EPSILON_GREEDY_EN adds a 16-bit LFSR. With probability
//            1/2**EPS_SHIFT, best_action is replaced by a pseudo-random action.
//            max_q is always the true maximum.
//
// Timing   : start sampled at edge T0, reads issued T1..TN, data T2..TN+1,
//            done with final results at TN+2 (N = 2**ACT_BITS).
//
// Revision : 1.0  initial release
// ============================================================================
module q_max_scanner #(
  parameter int Q_WIDTH    = 16,
  parameter int ACT_BITS   = 2,
  parameter int STATE_BITS = 6,
  parameter int EPS_SHIFT  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [STATE_BITS-1:0]          state_in,
  output logic                           busy,
  output logic                           q_rd_en,
  output logic [STATE_BITS+ACT_BITS-1:0] q_rd_addr,
  input  logic [Q_WIDTH-1:0]             q_rd_data,
  output logic                           done,
  output logic [Q_WIDTH-1:0]             max_q,
  output logic [ACT_BITS-1:0]            best_action
);

  localparam logic [ACT_BITS-1:0] c_LAST_ACT = '1;

  // The exploration mask is taken from the low LFSR bits.
  if (EPS_SHIFT < 1 || EPS_SHIFT > 16) begin : g_eps_range_chk
    $error("q_max_scanner: EPS_SHIFT must lie in 1..16");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_fsm;
  logic [STATE_BITS-1:0]   r_state_lat;   // state captured at start
  logic [ACT_BITS-1:0]     r_act;         // next action to issue
  logic                    r_vld;         // q_rd_data carries a datum this cycle
  logic [ACT_BITS-1:0]     r_rx_cnt;      // action index of the incoming datum
  logic [Q_WIDTH-1:0]      r_run_max;
  logic [ACT_BITS-1:0]     r_run_act;

  logic                    w_take;
  logic [Q_WIDTH-1:0]      w_cand_max;
  logic [ACT_BITS-1:0]     w_cand_act;
  logic                    w_last;
  logic [ACT_BITS-1:0]     w_pick_act;

  // The first datum always loads; later ones only if strictly greater, so
  // ties keep the lowest action index.
  assign w_take     = (r_rx_cnt == '0) || ($signed(q_rd_data) > $signed(r_run_max));
  assign w_cand_max = w_take ? q_rd_data : r_run_max;
  assign w_cand_act = w_take ? r_rx_cnt  : r_run_act;
  assign w_last     = r_vld && (r_rx_cnt == c_LAST_ACT);

`ifdef EPSILON_GREEDY_EN
  logic [15:0] r_lfsr;
  logic        w_explore;

  // Fibonacci LFSR, taps 16,14,13,11, free-running every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_explore  = (r_lfsr[EPS_SHIFT-1:0] == '0);
  assign w_pick_act = w_explore ? r_lfsr[15 -: ACT_BITS] : w_cand_act;
`else
  assign w_pick_act = w_cand_act;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_state_lat <= '0;
      r_act       <= '0;
      r_vld       <= 1'b0;
      r_rx_cnt    <= '0;
      r_run_max   <= '0;
      r_run_act   <= '0;
      busy        <= 1'b0;
      q_rd_en     <= 1'b0;
      q_rd_addr   <= '0;
      done        <= 1'b0;
      max_q       <= '0;
      best_action <= '0;
    end else begin
      // Data returns one cycle after the strobe, so the strobe delayed by one
      // marks the cycles in which q_rd_data is meaningful.
      r_vld <= q_rd_en;

      if (r_vld) begin
        r_run_max <= w_cand_max;
        r_run_act <= w_cand_act;
        r_rx_cnt  <= r_rx_cnt + 1'b1;
      end

      case (r_fsm)
        S_IDLE: begin
          q_rd_en <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            r_state_lat <= state_in;
            r_act       <= '0;
            r_rx_cnt    <= '0;
            busy        <= 1'b1;
            r_fsm       <= S_READ;
          end
        end

        S_READ: begin
          q_rd_en   <= 1'b1;
          q_rd_addr <= {r_state_lat, r_act};
          r_act     <= r_act + 1'b1;
          if (r_act == c_LAST_ACT) begin
            r_fsm <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          q_rd_en <= 1'b0;
          // Final result folds in the last datum combinationally so that it
          // is presented together with done.
          if (w_last) begin
            max_q       <= w_cand_max;
            best_action <= w_pick_act;
            done        <= 1'b1;
            r_fsm       <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          r_fsm <= S_IDLE;
        end

        default: begin
          r_fsm <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_q_max_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_q_max_scanner
// Purpose  : Self-checking bench for q_max_scanner. A behavioural RAM model
//            answers reads one cycle after the strobe; expected max/argmax
//            come from a plain array scan of the loaded Q values.
// Revision : 1.0  initial release
// ============================================================================
module tb_q_max_scanner;

  localparam int QW = 16;
  localparam int AB = 2;
  localparam int SB = 6;
  localparam int NA = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [SB-1:0] state_in = '0;
  logic          busy;
  logic          q_rd_en;
  logic [SB+AB-1:0] q_rd_addr;
  logic [QW-1:0] q_rd_data = '0;
  logic          done;
  logic [QW-1:0] max_q;
  logic [AB-1:0] best_action;

  logic [QW-1:0] mem [0:255];
  logic [QW-1:0] cur_q [NA];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int t0 = 0;
  int addr_q[$];
  int acyc_q[$];

  q_max_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .state_in    (state_in),
    .busy        (busy),
    .q_rd_en     (q_rd_en),
    .q_rd_addr   (q_rd_addr),
    .q_rd_data   (q_rd_data),
    .done        (done),
    .max_q       (max_q),
    .best_action (best_action)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (q_rd_en) q_rd_data <= mem[q_rd_addr];
  always @(negedge clk) if (q_rd_en) begin
    addr_q.push_back(int'(q_rd_addr));
    acyc_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: largest signed value, then the first index holding it.
  task automatic ref_model(output logic [QW-1:0] mx, output int ax);
    int best;
    best = -40000;
    for (int i = 0; i < NA; i++)
      if (int'($signed(cur_q[i])) > best) best = int'($signed(cur_q[i]));
    mx = QW'(best);
    ax = -1;
    for (int i = NA - 1; i >= 0; i--)
      if (int'($signed(cur_q[i])) == best) ax = i;
  endtask

  task automatic load_state(input logic [SB-1:0] s);
    for (int a = 0; a < NA; a++) mem[{s, 2'(a)}] = cur_q[a];
  endtask

  // Returns the done latency in cycles after T0, or -1 on timeout.
  // With glitch set, start is re-pulsed so that it is sampled at edge T3.
  task automatic run_scan(input logic [SB-1:0] s, input bit glitch, output int lat);
    addr_q.delete();
    acyc_q.delete();
    @(negedge clk);
    start    = 1'b1;
    state_in = s;
    @(posedge clk);
    #1;
    t0       = cyc;
    start    = 1'b0;
    state_in = SB'($urandom);
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (glitch && (cyc - t0) == 2) start = 1'b1;
      if ((cyc - t0) == 3) start = 1'b0;
      if (done) lat = cyc - t0;
    end
  endtask

  task automatic scan_and_check(input string tag, input logic [SB-1:0] s, input bit glitch);
    logic [QW-1:0] emx;
    int            eax;
    int            lat;
    load_state(s);
    ref_model(emx, eax);
    run_scan(s, glitch, lat);
    check({tag, "_latency"}, lat, NA + 2);
    check({tag, "_max_q"}, max_q, emx);
`ifndef EPSILON_GREEDY_EN
    check({tag, "_best_action"}, best_action, eax);
`endif
    @(negedge clk);
    check({tag, "_done_pulse_1cyc"}, done, 1'b0);
    check({tag, "_busy_cleared"}, busy, 1'b0);
  endtask

  initial begin
    int extra;
    logic [SB-1:0] rs;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", q_rd_en, 1'b0);
    check("rst_rd_addr", q_rd_addr, 0);
    check("rst_done", done, 1'b0);
    check("rst_max_q", max_q, 0);
    check("rst_best_action", best_action, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- case 1: state 5, address sequence and timing ----
    cur_q[0] = 16'h0100; cur_q[1] = 16'h0300; cur_q[2] = 16'h0200; cur_q[3] = 16'hFF00;
    scan_and_check("c1", 6'd5, 1'b0);
    check("c1_num_reads", addr_q.size(), NA);
    for (int a = 0; a < NA && a < addr_q.size(); a++) begin
      check($sformatf("c1_addr%0d", a), addr_q[a], 20 + a);
      check($sformatf("c1_addr%0d_cycle", a), acyc_q[a] - t0, a + 1);
    end
    check("c1_max_hold", max_q, 16'h0300);

    // ---- case 2: all negative, tie on 0xFF80 ----
    cur_q[0] = 16'hFE00; cur_q[1] = 16'hFF80; cur_q[2] = 16'hF000; cur_q[3] = 16'hFF80;
    scan_and_check("c2", 6'd17, 1'b0);

    // ---- case 3: all zero, then signed extremes ----
    cur_q[0] = 16'h0000; cur_q[1] = 16'h0000; cur_q[2] = 16'h0000; cur_q[3] = 16'h0000;
    scan_and_check("c3a", 6'd63, 1'b0);
    cur_q[0] = 16'h8000; cur_q[1] = 16'h7FFF; cur_q[2] = 16'h8000; cur_q[3] = 16'h0000;
    scan_and_check("c3b", 6'd0, 1'b0);

    // ---- case 4: start during scan ignored, next start honoured ----
    cur_q[0] = 16'h0010; cur_q[1] = 16'h0020; cur_q[2] = 16'h0030; cur_q[3] = 16'h0005;
    scan_and_check("c4", 6'd9, 1'b1);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("c4_no_extra_scan", extra, 0);
    cur_q[0] = 16'h0400; cur_q[1] = 16'h0020; cur_q[2] = 16'h0400; cur_q[3] = 16'h0005;
    scan_and_check("c4_next", 6'd10, 1'b0);

    // ---- randomized scans (values drawn from a small pool sometimes to force ties) ----
    for (int n = 0; n < 24; n++) begin
      rs = SB'($urandom);
      for (int a = 0; a < NA; a++) begin
        if ($urandom_range(0, 1) == 0) cur_q[a] = QW'($urandom_range(0, 2)) - 16'd1;
        else                           cur_q[a] = QW'($urandom);
      end
      scan_and_check($sformatf("rnd%0d", n), rs, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // ---- case 5: async reset mid-scan ----
    cur_q[0] = 16'h0111; cur_q[1] = 16'h0222; cur_q[2] = 16'h0333; cur_q[3] = 16'h0444;
    load_state(6'd33);
    @(negedge clk);
    start = 1'b1; state_in = 6'd33;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("c5_busy", busy, 1'b0);
    check("c5_rd_en", q_rd_en, 1'b0);
    check("c5_done", done, 1'b0);
    check("c5_max_q", max_q, 0);
    check("c5_best_action", best_action, 0);
    check("c5_rd_addr", q_rd_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("c5_no_done", extra, 0);
    scan_and_check("c5_recover", 6'd33, 1'b0);

`ifdef EPSILON_GREEDY_EN
    // ---- case 6: exploration rate ----
    begin
      int other;
      int badmax;
      int lat;
      other  = 0;
      badmax = 0;
      cur_q[0] = 16'h0100; cur_q[1] = 16'h0300; cur_q[2] = 16'h0200; cur_q[3] = 16'hFF00;
      load_state(6'd5);
      for (int n = 0; n < 1000; n++) begin
        run_scan(6'd5, 1'b0, lat);
        if (lat != NA + 2 || max_q !== 16'h0300) badmax++;
        if (best_action !== 2'd1) other++;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      check("c6_max_always", badmax, 0);
      check("c6_explore_rate_in_range", (other >= 50 && other <= 140), 1'b1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
